framebuffer_scheduler: RTL and testbench
========================================

// Module: framebuffer_scheduler
// PURPOSE
//  Sole owner of the single-port 64K x 15-bit frame-buffer block RAM. The VGA display read
//  stream has absolute priority on visible cycles. Host pixel writes are queued in a FIFO and
//  drained into the RAM on blanking cycles. A clear-screen fill engine also writes the RAM
//  on blanking cycles. Sits between VGA_Controller/pixel pipeline, drawing logic and BlockRam.
// PARAMETERS
//  ADDR_W      16  RAM address width; display address is {col[7:0], row[7:0]}
//  DATA_W      15  pixel width, RGB555 packed {r[14:10], g[9:5], b[4:0]}
//  FIFO_DEPTH  8   write-queue entries; power of 2, >= 2
// PORTS
//  clock         in   1                       system clock (CLOCK_50 domain)
//  reset_n       in   1                       asynchronous, active-low reset
//  disp_visible  in   1                       display needs the RAM this cycle
//  disp_address  in   ADDR_W                  display read address
//  disp_pixel    out  DATA_W                  display pixel, = ram_q (RAM read latency only)
//  wr_valid      in   1                       host write request
//  wr_ready      out  1                       FIFO accepts; push when wr_valid & wr_ready
//  wr_address    in   ADDR_W                  host write address
//  wr_data       in   DATA_W                  host write pixel
//  fill_start    in   1                       one-cycle pulse: clear whole buffer
//  fill_color    in   DATA_W                  fill pixel, sampled on accepted fill_start
//  fill_busy     out  1                       fill pending or in progress
//  fifo_level    out  $clog2(FIFO_DEPTH)+1    current FIFO occupancy
//  ram_address   out  ADDR_W                  to BlockRam.address
//  ram_data      out  DATA_W                  to BlockRam.data
//  ram_wren      out  1                       to BlockRam.wren
//  ram_q         in   DATA_W                  from BlockRam.q
// BEHAVIOUR
//  Reset (async, reset_n=0): FIFO emptied, state=IDLE, fill_addr=0, fill_color reg=0.
//   Outputs: ram_wren=0, fill_busy=0, fifo_level=0, wr_ready=1 after release.
//  ram_* outputs are combinational from registered state, FIFO head and disp_* inputs.
//   This adds zero latency to the display path.
//  Per-cycle grant, in priority order:
//   1. disp_visible=1: ram_address=disp_address, ram_wren=0. No FIFO pop, no fill advance.
//   2. state=FILL: ram_address=fill_addr, ram_data=fill_color, ram_wren=1; fill_addr++.
//   3. FIFO non-empty: write head entry (address, data), ram_wren=1, pop.
//   4. Otherwise: ram_address=disp_address, ram_wren=0.
//  State machine:
//   IDLE      -> FILL_WAIT on fill_start. Latch fill_color and set fill_addr=0.
//   FILL_WAIT -> FILL once FIFO is empty; same cycle if already empty at entry.
//   FILL      -> IDLE after the cycle that writes address 2^ADDR_W-1.
//                fill_addr wraps to 0; the fill is never repeated.
//   fill_start is ignored in FILL_WAIT and FILL.
//  fill_busy=1 in FILL_WAIT and FILL.
//   Rises the cycle after fill_start; falls the cycle after the last fill write.
//  wr_ready = (state==IDLE) & ~full. Host writes are held off during a fill.
//   Entries queued before fill_start are written before the fill, then overwritten by it.
//  FIFO:
//   - Strict in-order.
//   - Push and pop in the same cycle leave the level unchanged.
//   - Push when full is impossible (wr_ready=0).
//   - Pop only under grant 3.
//  Writes are never dropped; a burst of visible cycles simply stalls draining.
//  Reset mid-fill or mid-drain: the operation is aborted and queued entries are discarded.
//   ram_wren goes to 0 immediately (asynchronously).
// TESTING (ADDR_W=16, DATA_W=15, FIFO_DEPTH=8)
//  1. Reset pulse -> ram_wren=0, fill_busy=0, fifo_level=0; wr_ready=1 after release.
//  2. disp_visible=1; push 8 writes (0x0100..0x0107, data 0x7C00+i).
//     -> wr_ready=0 after the 8th; no wren.
//     Then drop visible -> 8 consecutive writes, in order, exact address/data.
//  3. disp_visible toggling every cycle, 4 writes queued.
//     -> wren only on non-visible cycles; ram_address=disp_address on visible ones.
//  4. 3 entries queued, fill_start with fill_color=0x001F, visible=0.
//     -> 3 FIFO writes, then 65536 fill writes 0x0000..0xFFFF.
//     fill_busy drops the cycle after 0xFFFF; fill_start mid-fill has no effect.
//  5. reset_n=0 while fill_addr=0x1234.
//     -> ram_wren=0 at once, fill_busy=0; no further writes after release.
//  6. fifo_level=4, push and pop in the same cycle -> level stays 4; order preserved.

Source files
------------

// File: rtl/framebuffer_scheduler.sv
// Frame-buffer RAM arbiter: display reads first, then clear-screen fill,
// then queued host writes, all sharing one single-port block RAM.
module framebuffer_scheduler #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 15,
    parameter int FIFO_DEPTH = 8,
    localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              disp_visible,
    input  logic [ADDR_W-1:0] disp_address,
    output logic [DATA_W-1:0] disp_pixel,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic [PTR_W:0]    fifo_level,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL_WAIT,
        S_FILL
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_fill_addr;
    logic [DATA_W-1:0] r_fill_color;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W:0]    r_wptr;
    logic [PTR_W:0]    r_rptr;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_fill_go;
    logic w_fill_last;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

    assign wr_ready    = (r_state == S_IDLE) && !w_full;
    assign w_push      = wr_valid && wr_ready;
    assign w_fill_go   = !disp_visible && (r_state == S_FILL);
    assign w_pop       = !disp_visible && (r_state != S_FILL) && !w_empty;
    assign w_fill_last = (r_fill_addr == {ADDR_W{1'b1}});

    assign fill_busy  = (r_state != S_IDLE);
    assign fifo_level = r_wptr - r_rptr;
    assign disp_pixel = ram_q;

    // Display wins on visible cycles; otherwise fill, then FIFO drain.
    always_comb begin
        ram_address = disp_address;
        ram_data    = r_fifo_data[r_rptr[PTR_W-1:0]];
        ram_wren    = 1'b0;
        if (w_fill_go) begin
            ram_address = r_fill_addr;
            ram_data    = r_fill_color;
            ram_wren    = 1'b1;
        end else if (w_pop) begin
            ram_address = r_fifo_addr[r_rptr[PTR_W-1:0]];
            ram_wren    = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:      if (fill_start) w_state_nxt = S_FILL_WAIT;
            S_FILL_WAIT: if (w_empty) w_state_nxt = S_FILL;
            S_FILL:      if (w_fill_go && w_fill_last) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_fill_addr  <= '0;
            r_fill_color <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && fill_start) begin
                r_fill_addr  <= '0;
                r_fill_color <= fill_color;
            end else if (w_fill_go) begin
                r_fill_addr <= r_fill_addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: pointers alone define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_addr[r_wptr[PTR_W-1:0]] <= wr_address;
            r_fifo_data[r_wptr[PTR_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_framebuffer_scheduler.sv
// Directed testbench for framebuffer_scheduler.
// Inputs change 1ns after the rising edge; outputs are sampled 5ns after it.
module tb_framebuffer_scheduler;

    logic        clock;
    logic        reset_n;
    logic        disp_visible;
    logic [15:0] disp_address;
    logic [14:0] disp_pixel;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_address;
    logic [14:0] wr_data;
    logic        fill_start;
    logic [14:0] fill_color;
    logic        fill_busy;
    logic [3:0]  fifo_level;
    logic [15:0] ram_address;
    logic [14:0] ram_data;
    logic        ram_wren;
    logic [14:0] ram_q;

    int n_cmp = 0;
    int n_bad = 0;

    framebuffer_scheduler #(
        .ADDR_W(16),
        .DATA_W(15),
        .FIFO_DEPTH(8)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .disp_visible(disp_visible),
        .disp_address(disp_address),
        .disp_pixel(disp_pixel),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_address(wr_address),
        .wr_data(wr_data),
        .fill_start(fill_start),
        .fill_color(fill_color),
        .fill_busy(fill_busy),
        .fifo_level(fifo_level),
        .ram_address(ram_address),
        .ram_data(ram_data),
        .ram_wren(ram_wren),
        .ram_q(ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        disp_visible = 1'b0;
        disp_address = '0;
        wr_valid     = 1'b0;
        wr_address   = '0;
        wr_data      = '0;
        fill_start   = 1'b0;
        fill_color   = '0;
        ram_q        = 15'h1234;
        #3;
        n_cmp++;
        if (ram_wren !== 1'b0 || fill_busy !== 1'b0 || fifo_level !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_out: wren=%b busy=%b level=%0d required 0/0/0",
                     ram_wren, fill_busy, fifo_level);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
        #4;
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: wr_ready=%b required 1", wr_ready);
        end
        n_cmp++;
        if (disp_pixel !== 15'h1234) begin
            n_bad++;
            $display("FAIL disp_pixel: got %h required 1234", disp_pixel);
        end
    endtask

    task automatic test_full_queue();
        disp_visible = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            wr_valid   = 1'b1;
            wr_address = 16'(16'h0100 + i);
            wr_data    = 15'(15'h7C00 + i);
            #4;
            n_cmp++;
            if (wr_ready !== 1'b1 || ram_wren !== 1'b0) begin
                n_bad++;
                $display("FAIL fill_queue[%0d]: ready=%b wren=%b required 1/0",
                         i, wr_ready, ram_wren);
            end
        end
        tick();
        wr_valid = 1'b0;
        #4;
        n_cmp++;
        if (wr_ready !== 1'b0 || fifo_level !== 4'd8 || ram_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL queue_full: ready=%b level=%0d wren=%b required 0/8/0",
                     wr_ready, fifo_level, ram_wren);
        end
        tick();
        disp_visible = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #4;
            n_cmp++;
            if (ram_wren !== 1'b1 || ram_address !== 16'(16'h0100 + i) ||
                ram_data !== 15'(15'h7C00 + i)) begin
                n_bad++;
                $display("FAIL drain[%0d]: wren=%b addr=%h data=%h required 1/%h/%h",
                         i, ram_wren, ram_address, ram_data,
                         16'(16'h0100 + i), 15'(15'h7C00 + i));
            end
            tick();
        end
        #4;
        n_cmp++;
        if (ram_wren !== 1'b0 || fifo_level !== 4'd0 || wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL drained: wren=%b level=%0d ready=%b required 0/0/1",
                     ram_wren, fifo_level, wr_ready);
        end
    endtask

    task automatic test_visible_toggle();
        int j;
        disp_visible = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            wr_valid   = 1'b1;
            wr_address = 16'(16'h0200 + i);
            wr_data    = 15'(15'h1000 + i);
        end
        tick();
        wr_valid = 1'b0;
        j = 0;
        for (int k = 0; k < 8; k++) begin
            disp_visible = (k % 2 == 0);
            disp_address = 16'(16'hA000 + k);
            #4;
            n_cmp++;
            if (disp_visible) begin
                if (ram_wren !== 1'b0 || ram_address !== 16'(16'hA000 + k)) begin
                    n_bad++;
                    $display("FAIL toggle_vis[%0d]: wren=%b addr=%h required 0/%h",
                             k, ram_wren, ram_address, 16'(16'hA000 + k));
                end
            end else begin
                if (ram_wren !== 1'b1 || ram_address !== 16'(16'h0200 + j) ||
                    ram_data !== 15'(15'h1000 + j)) begin
                    n_bad++;
                    $display("FAIL toggle_wr[%0d]: wren=%b addr=%h data=%h required 1/%h/%h",
                             k, ram_wren, ram_address, ram_data,
                             16'(16'h0200 + j), 15'(15'h1000 + j));
                end
                j++;
            end
            tick();
        end
        disp_visible = 1'b0;
        #4;
        n_cmp++;
        if (fifo_level !== 4'd0 || ram_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL toggle_end: level=%0d wren=%b required 0/0",
                     fifo_level, ram_wren);
        end
    endtask

    task automatic test_fill();
        int  nwr;
        int  nerr;
        bit  pulsed;
        bit  ready_seen;
        logic [15:0] exp_a;
        logic [14:0] exp_d;
        disp_visible = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            wr_valid   = 1'b1;
            wr_address = 16'(16'h0300 + i);
            wr_data    = 15'(15'h0300 + i);
        end
        tick();
        wr_valid     = 1'b0;
        disp_visible = 1'b0;
        fill_start   = 1'b1;
        fill_color   = 15'h001F;
        nwr        = 0;
        nerr       = 0;
        pulsed     = 1'b0;
        ready_seen = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            if (c > 0) begin
                fill_start = 1'b0;
                if (nwr >= 1000 && !pulsed) begin
                    pulsed     = 1'b1;
                    fill_start = 1'b1;
                    fill_color = 15'h7FFF;
                end
            end
            #4;
            if (c == 1) begin
                n_cmp++;
                if (fill_busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy_rise: fill_busy=%b required 1", fill_busy);
                end
            end
            if (c > 0 && wr_ready === 1'b1) ready_seen = 1'b1;
            if (ram_wren === 1'b1) begin
                if (nwr < 3) begin
                    exp_a = 16'(16'h0300 + nwr);
                    exp_d = 15'(15'h0300 + nwr);
                end else begin
                    exp_a = 16'(nwr - 3);
                    exp_d = 15'h001F;
                end
                if (ram_address !== exp_a || ram_data !== exp_d) begin
                    if (nerr == 0)
                        $display("first bad fill write #%0d: addr=%h data=%h want %h/%h",
                                 nwr, ram_address, ram_data, exp_a, exp_d);
                    nerr++;
                end
                nwr++;
            end
            if (nwr == 65539) break;
            tick();
        end
        fill_start = 1'b0;
        n_cmp++;
        if (nwr != 65539) begin
            n_bad++;
            $display("FAIL fill_count: got %0d writes required 65539", nwr);
        end
        n_cmp++;
        if (nerr != 0) begin
            n_bad++;
            $display("FAIL fill_seq: %0d bad writes required 0", nerr);
        end
        n_cmp++;
        if (ready_seen) begin
            n_bad++;
            $display("FAIL fill_ready: wr_ready seen 1 during fill, required 0");
        end
        tick();
        #4;
        n_cmp++;
        if (fill_busy !== 1'b0 || ram_wren !== 1'b0 || wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_fall: busy=%b wren=%b ready=%b required 0/0/1",
                     fill_busy, ram_wren, wr_ready);
        end
        nerr = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            #4;
            if (ram_wren !== 1'b0 || fill_busy !== 1'b0) nerr++;
        end
        n_cmp++;
        if (nerr != 0) begin
            n_bad++;
            $display("FAIL fill_repeat: %0d active cycles after fill required 0", nerr);
        end
    endtask

    task automatic test_reset_mid_fill();
        bit found;
        int nact;
        tick();
        fill_start = 1'b1;
        fill_color = 15'h0AAA;
        tick();
        fill_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 16'h3000; c++) begin
            #4;
            if (ram_wren === 1'b1 && ram_address === 16'h1234) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL mid_fill_reach: write to 1234 not seen, required seen");
        end
        n_cmp++;
        if (ram_data !== 15'h0AAA) begin
            n_bad++;
            $display("FAIL mid_fill_data: data=%h required 0aaa", ram_data);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (ram_wren !== 1'b0 || fill_busy !== 1'b0 || fifo_level !== 4'd0) begin
            n_bad++;
            $display("FAIL async_reset: wren=%b busy=%b level=%0d required 0/0/0",
                     ram_wren, fill_busy, fifo_level);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        nact = 0;
        for (int c = 0; c < 20; c++) begin
            #4;
            if (ram_wren !== 1'b0 || fill_busy !== 1'b0) nact++;
            tick();
        end
        n_cmp++;
        if (nact != 0 || wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset: %0d active cycles ready=%b required 0/1",
                     nact, wr_ready);
        end
    endtask

    task automatic test_push_pop();
        disp_visible = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            wr_valid   = 1'b1;
            wr_address = 16'(16'h0400 + i);
            wr_data    = 15'(15'h0400 + i);
        end
        tick();
        wr_valid = 1'b0;
        #4;
        n_cmp++;
        if (fifo_level !== 4'd4) begin
            n_bad++;
            $display("FAIL pp_level_pre: level=%0d required 4", fifo_level);
        end
        tick();
        disp_visible = 1'b0;
        wr_valid     = 1'b1;
        wr_address   = 16'h0404;
        wr_data      = 15'h0404;
        #4;
        n_cmp++;
        if (ram_wren !== 1'b1 || ram_address !== 16'h0400 || wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL pp_both: wren=%b addr=%h ready=%b required 1/0400/1",
                     ram_wren, ram_address, wr_ready);
        end
        tick();
        wr_valid = 1'b0;
        #4;
        n_cmp++;
        if (fifo_level !== 4'd4) begin
            n_bad++;
            $display("FAIL pp_level_post: level=%0d required 4", fifo_level);
        end
        for (int i = 1; i < 5; i++) begin
            n_cmp++;
            if (ram_wren !== 1'b1 || ram_address !== 16'(16'h0400 + i) ||
                ram_data !== 15'(15'h0400 + i)) begin
                n_bad++;
                $display("FAIL pp_order[%0d]: wren=%b addr=%h data=%h required 1/%h/%h",
                         i, ram_wren, ram_address, ram_data,
                         16'(16'h0400 + i), 15'(15'h0400 + i));
            end
            tick();
            #4;
        end
        n_cmp++;
        if (fifo_level !== 4'd0 || ram_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL pp_end: level=%0d wren=%b required 0/0",
                     fifo_level, ram_wren);
        end
    endtask

    initial begin
        test_reset();
        test_full_queue();
        test_visible_toggle();
        test_fill();
        test_reset_mid_fill();
        test_push_pop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
